mmu_request_arbiter: RTL and testbench

Round-robin arbiter that shares the single core-side request port of the memory management unit between N_REQ load/store requesters (reservation-station issue ports). It selects one requester, locks the grant until the MMU accepts that request, then rotates priority. It sits between the issue logic and the MMU core port (rsv_id/valid/data/address/opcode/ready). The MMU result path (CDB) is not touched.

---
 rtl/fcpu_pkg.sv | 17 +
 rtl/rr_pick.sv | 47 ++++
 rtl/mmu_request_arbiter.sv | 139 +++++++++++++
 tb/tb_mmu_request_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fcpu_pkg.sv
// rtl/fcpu_pkg.sv - shared core widths and MMU request arbiter state type
//
// Purpose: common widths used by the core-side MMU interface, plus the
// arbiter FSM state encoding.
// Ports: none (package).
package fcpu_pkg;

    localparam int RSV_ID_W = 4;
    localparam int DATA_W   = 32;
    localparam int INSTR_W  = 7;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin find-first
//
// Purpose: returns the first requester at or above ptr_i (with wrap-around)
// whose request bit is set and whose mask bit is clear.
// Ports:
//   req_i   - request vector
//   mask_i  - requesters excluded from this pick
//   ptr_i   - highest-priority index
//   found_o - a winner exists
//   idx_o   - index of the winner (0 when none)
module rr_pick #(
    parameter int N_REQ   = 4,
    parameter int GRANT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0]   req_i,
    input  logic [N_REQ-1:0]   mask_i,
    input  logic [GRANT_W-1:0] ptr_i,
    output logic               found_o,
    output logic [GRANT_W-1:0] idx_o
);

    logic [N_REQ-1:0]   avail;
    logic [2*N_REQ-1:0] rotated;
    logic [GRANT_W:0]   sum;

    // Rotate so that bit 0 of rotated is requester ptr_i; the doubled copy
    // provides the wrap-around without a modulo on the index.
    always_comb begin
        avail   = req_i & ~mask_i;
        rotated = {avail, avail} >> ptr_i;
        found_o = 1'b0;
        idx_o   = '0;
        sum     = '0;
        // Descending scan: the lowest offset is assigned last and wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found_o = 1'b1;
                sum     = {1'b0, ptr_i} + (GRANT_W+1)'(k);
                if (sum >= (GRANT_W+1)'(N_REQ)) begin
                    sum = sum - (GRANT_W+1)'(N_REQ);
                end
                idx_o = sum[GRANT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mmu_request_arbiter.sv
// rtl/mmu_request_arbiter.sv - round-robin arbiter for the MMU core request port
//
// Purpose: shares the single MMU request port among N_REQ issue ports.
// A grant is held until the MMU accepts it, then priority rotates past it.
// Ports:
//   clk, nrst                      - clock, async active-low reset
//   req_valid/rsv_id/data/address/opcode - flattened per-requester requests
//   req_ready                      - per-requester accept (one-hot or zero)
//   rsv_id/valid/data/address/opcode - request towards the MMU
//   ready                          - MMU accept
//   grant_id                       - registered current grant index
//   busy                           - arbiter holds a grant
//   proto_err                      - sticky requester protocol violation
module mmu_request_arbiter
    import fcpu_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int GRANT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*RSV_ID_W-1:0] req_rsv_id,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ*DATA_W-1:0]   req_address,
    input  logic [N_REQ*INSTR_W-1:0]  req_opcode,
    output logic [N_REQ-1:0]          req_ready,
    output logic [RSV_ID_W-1:0]       rsv_id,
    output logic                      valid,
    output logic [DATA_W-1:0]         data,
    output logic [DATA_W-1:0]         address,
    output logic [INSTR_W-1:0]        opcode,
    input  logic                      ready,
    output logic [GRANT_W-1:0]        grant_id,
    output logic                      busy,
    output logic                      proto_err
);

    arb_state_e         state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [GRANT_W-1:0] ptr_q, ptr_d;
    logic               err_q, err_d;

    logic               cur_valid;
    logic [N_REQ-1:0]   grant_oh;
    logic [GRANT_W-1:0] next_ptr;
    logic [N_REQ-1:0]   pick_mask;
    logic [GRANT_W-1:0] pick_ptr;
    logic               pick_found;
    logic [GRANT_W-1:0] pick_idx;

    assign cur_valid = req_valid[grant_q];
    assign grant_oh  = N_REQ'(1) << grant_q;
    assign next_ptr  = (grant_q == GRANT_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

    // One picker serves both IDLE arbitration and completion re-arbitration;
    // in BUSY the completing grant is masked because its valid is consumed.
    assign pick_mask = (state_q == ARB_BUSY) ? grant_oh : '0;
    assign pick_ptr  = (state_q == ARB_BUSY) ? next_ptr : ptr_q;

    rr_pick #(
        .N_REQ   (N_REQ),
        .GRANT_W (GRANT_W)
    ) u_pick (
        .req_i   (req_valid),
        .mask_i  (pick_mask),
        .ptr_i   (pick_ptr),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d = ARB_BUSY;
                    grant_d = pick_idx;
                end
            end
            ARB_BUSY: begin
                if (!cur_valid) begin
                    // Requester withdrew before acceptance; ptr is left alone.
                    state_d = ARB_IDLE;
                    err_d   = 1'b1;
                end else if (ready) begin
                    ptr_d = next_ptr;
                    if (pick_found) begin
                        grant_d = pick_idx;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        valid     = 1'b0;
        rsv_id    = '0;
        data      = '0;
        address   = '0;
        opcode    = '0;
        req_ready = '0;
        if (state_q == ARB_BUSY) begin
            valid   = cur_valid;
            rsv_id  = req_rsv_id[grant_q*RSV_ID_W +: RSV_ID_W];
            data    = req_data[grant_q*DATA_W +: DATA_W];
            address = req_address[grant_q*DATA_W +: DATA_W];
            opcode  = req_opcode[grant_q*INSTR_W +: INSTR_W];
            if (cur_valid && ready) begin
                req_ready = grant_oh;
            end
        end
    end

    assign grant_id  = grant_q;
    assign busy      = (state_q == ARB_BUSY);
    assign proto_err = err_q;

endmodule

// File: tb/tb_mmu_request_arbiter.sv
// tb/tb_mmu_request_arbiter.sv - directed self-checking bench for mmu_request_arbiter
module tb_mmu_request_arbiter;
    import fcpu_pkg::*;

    localparam int N = 4;
    localparam int GW = 2;

    logic              clk;
    logic              nrst;
    logic [N-1:0]      req_valid;
    logic [N*RSV_ID_W-1:0] req_rsv_id;
    logic [N*DATA_W-1:0]   req_data;
    logic [N*DATA_W-1:0]   req_address;
    logic [N*INSTR_W-1:0]  req_opcode;
    logic [N-1:0]      req_ready;
    logic [RSV_ID_W-1:0] rsv_id;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] address;
    logic [INSTR_W-1:0] opcode;
    logic              ready;
    logic [GW-1:0]     grant_id;
    logic              busy;
    logic              proto_err;

    int total = 0;
    int bad   = 0;

    mmu_request_arbiter #(.N_REQ(N)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .req_valid   (req_valid),
        .req_rsv_id  (req_rsv_id),
        .req_data    (req_data),
        .req_address (req_address),
        .req_opcode  (req_opcode),
        .req_ready   (req_ready),
        .rsv_id      (rsv_id),
        .valid       (valid),
        .data        (data),
        .address     (address),
        .opcode      (opcode),
        .ready       (ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tasks start and end at posedge+1.
    task automatic do_reset();
        nrst = 1'b0;
        req_valid = '0;
        #2;
        nrst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        req_valid = '0;
        ready = 1'b0;
        #3;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant got=%0d want=0", grant_id); end
        total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_proto_err got=%b want=0", proto_err); end
        total++; if (data !== 32'h0 || address !== 32'h0 || opcode !== 7'h0 || rsv_id !== 4'h0) begin
            bad++; $display("FAIL reset_payload got=%h/%h/%h/%h want=0", data, address, opcode, rsv_id);
        end
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        ready = 1'b1;
        req_valid = 4'b0100;
        @(negedge clk);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL single_idle_valid got=%b want=0", valid); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", valid); end
        total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL single_grant got=%0d want=2", grant_id); end
        total++; if (opcode !== 7'd10) begin bad++; $display("FAIL single_opcode got=%0d want=10", opcode); end
        total++; if (address !== 32'hA000_0002) begin bad++; $display("FAIL single_address got=%h want=a0000002", address); end
        total++; if (data !== 32'hD000_0002 || rsv_id !== 4'd3) begin bad++; $display("FAIL single_payload got=%h/%0d want=d0000002/3", data, rsv_id); end
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_req_ready got=%b want=0100", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        total++; if (busy !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL single_idle_after got=%b/%b want=0/0", busy, valid); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_ready_after got=%b want=0000", req_ready); end
        total++; if (dut.ptr_q !== 2'd3) begin bad++; $display("FAIL single_ptr got=%0d want=3", dut.ptr_q); end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        int exp_g[5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] rr;
        logic [N-1:0] one;
        do_reset();
        ready = 1'b1;
        req_valid = 4'b1111;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            one = 4'b0001 << exp_g[k];
            @(negedge clk);
            total++; if (grant_id !== 2'(exp_g[k])) begin bad++; $display("FAIL rr_grant[%0d] got=%0d want=%0d", k, grant_id, exp_g[k]); end
            total++; if (req_ready !== one || valid !== 1'b1) begin bad++; $display("FAIL rr_ready[%0d] got=%b/%b want=%b/1", k, req_ready, valid, one); end
            rr = req_ready;
            @(posedge clk); #1;
            req_valid = req_valid & ~rr;
            if (k == 0) req_valid[0] = 1'b1;
        end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_idle got=%b want=0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int pulses = 0;
        logic [N-1:0] rr;
        do_reset();
        ready = 1'b0;
        req_valid = 4'b0010;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (valid !== 1'b1 || grant_id !== 2'd1 || req_ready !== 4'b0000 || data !== 32'hD000_0001) begin
                bad++; $display("FAIL bp_hold[%0d] got=%b/%0d/%b/%h want=1/1/0000/d0000001", k, valid, grant_id, req_ready, data);
            end
            @(posedge clk); #1;
        end
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (req_ready == 4'b0010) pulses++;
            rr = req_ready;
            @(posedge clk); #1;
            req_valid = req_valid & ~rr;
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL bp_pulses got=%0d want=1", pulses); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle got=%b want=0", busy); end
    endtask

    task automatic test_fairness();
        int exp_g[3] = '{0, 3, 0};
        logic [N-1:0] rr;
        do_reset();
        ready = 1'b1;
        req_valid = 4'b0001;
        @(posedge clk); #1;
        req_valid[3] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (grant_id !== 2'(exp_g[k]) || valid !== 1'b1) begin bad++; $display("FAIL fair_grant[%0d] got=%0d want=%0d", k, grant_id, exp_g[k]); end
            rr = req_ready;
            @(posedge clk); #1;
            req_valid = req_valid & ~rr;
            if (rr[0] && k < 2) req_valid[0] = 1'b1;
        end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fair_idle got=%b want=0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_proto_drop();
        do_reset();
        ready = 1'b0;
        req_valid = 4'b0100;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (busy !== 1'b1 || grant_id !== 2'd2) begin bad++; $display("FAIL drop_grant got=%b/%0d want=1/2", busy, grant_id); end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        total++; if (valid !== 1'b0 || proto_err !== 1'b0) begin bad++; $display("FAIL drop_comb got=%b/%b want=0/0", valid, proto_err); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (busy !== 1'b0 || proto_err !== 1'b1) begin bad++; $display("FAIL drop_err got=%b/%b want=0/1", busy, proto_err); end
        total++; if (dut.ptr_q !== 2'd0) begin bad++; $display("FAIL drop_ptr got=%0d want=0", dut.ptr_q); end
        @(posedge clk); #1;
        ready = 1'b1;
        req_valid = 4'b0001;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (req_ready !== 4'b0001 || proto_err !== 1'b1) begin bad++; $display("FAIL drop_sticky got=%b/%b want=0001/1", req_ready, proto_err); end
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        ready = 1'b0;
        req_valid = 4'b1000;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (busy !== 1'b1 || grant_id !== 2'd3 || proto_err !== 1'b1) begin
            bad++; $display("FAIL ar_pre got=%b/%0d/%b want=1/3/1", busy, grant_id, proto_err);
        end
        #2;
        nrst = 1'b0;
        #1;
        total++; if (valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            bad++; $display("FAIL ar_forced got=%b/%b/%b want=0/0/0000", valid, busy, req_ready);
        end
        total++; if (proto_err !== 1'b0 || grant_id !== 2'd0) begin bad++; $display("FAIL ar_regs got=%b/%0d want=0/0", proto_err, grant_id); end
        @(posedge clk); #1;
        nrst = 1'b1;
        req_valid = 4'b1001;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (busy !== 1'b1 || grant_id !== 2'd0 || rsv_id !== 4'd1) begin
            bad++; $display("FAIL ar_restart got=%b/%0d/%0d want=1/0/1", busy, grant_id, rsv_id);
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            req_rsv_id[i*RSV_ID_W +: RSV_ID_W] = RSV_ID_W'(i + 1);
            req_data[i*DATA_W +: DATA_W]       = 32'hD000_0000 + 32'(i);
            req_address[i*DATA_W +: DATA_W]    = 32'hA000_0000 + 32'(i);
            req_opcode[i*INSTR_W +: INSTR_W]   = INSTR_W'(i + 8);
        end
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_fairness();
        test_proto_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
